intc_irq_sequencer: RTL and testbench
=====================================

# intc_irq_sequencer

Single-master AXI-Lite controller that owns the `axi_intc` instance in the SoC peripheral subsystem. After reset it programs the interrupt controller (IER, then MER). It then services the controller's `irq` output: read IVR, present the vector to the core-side consumer, write IAR on acceptance. It sits between the `axi_intc_wrapper` slave port and the consumer of interrupt vectors, replacing software polling of the controller.

## Interface
- `C_NUM_INTR_INPUTS`, 8: sources in the controlled intc; 1..32.
- `C_BASE_ADDR`, 32'h0: intc base address; register offsets are added to it.
- `C_IER_INIT`, 32'hFF: value written to IER at init; bits at or above `C_NUM_INTR_INPUTS` are forced to 0.
- `aclk`  in  1  clock; the single clock domain.
- `aresetn`  in  1  asynchronous active-low reset.
- `mst`  AXI_LITE.Master  32-bit addr/data  port to the intc wrapper `slv`.
- `irq_i`  in  1  level interrupt from the intc `irq_o`.
- `init_done_o`  out  1  high once the MER write has completed; stays high until reset.
- `vec_valid_o`  out  1  a vector is being presented.
- `vec_id_o`  out  5  vector number, valid while `vec_valid_o` is high.
- `vec_ready_i`  in  1  consumer accepts the vector.
- `err_o`  out  1  sticky: any BRESP or RRESP not equal to OKAY.
- `spurious_cnt_o`  out  8  saturating count of IVR reads that returned all-ones.

## Operation
- Register offsets: IER 0x08, IAR 0x0C, IVR 0x18, MER 0x1C.
- FSM states and transitions:
  - INIT_IER: write IER = masked `C_IER_INIT`, then go to INIT_MER.
  - INIT_MER: write MER = 32'h3 (ME and HIE), then go to IDLE.
  - IDLE: if `irq_i` is high, go to RD_IVR.
  - RD_IVR: read IVR.
    - Data == 32'hFFFF_FFFF: increment `spurious_cnt_o` (stops at 255), then go to IDLE.
    - Otherwise: latch `vec_id_o` = rdata[4:0], then go to PRESENT.
  - PRESENT: hold `vec_valid_o` until `vec_ready_i`, then go to WR_IAR.
  - WR_IAR: write IAR = 32'h1 << `vec_id_o`, then go to IDLE.
- Write transaction:
  - AW and W are asserted together with `w_strb` = 4'hF.
  - Each valid deasserts independently in the cycle after its ready is seen.
  - `b_ready` is held high and the state advances on the B beat.
- Read transaction: assert AR, hold `r_ready` high, and advance on the R beat.
- Only one transaction is ever outstanding.
- A non-OKAY response sets `err_o` and the FSM advances as if the response were OKAY; no retry.
- `irq_i` is sampled only in IDLE; a level that is still high on return to IDLE restarts service.

## Timing
- Reset values:
  - All `mst` valids = 0, `b_ready`/`r_ready` = 0.
  - `init_done_o` = 0, `vec_valid_o` = 0, `vec_id_o` = 0, `err_o` = 0, `spurious_cnt_o` = 0.
  - State = INIT_IER.
- First AW/W valid is asserted in the first clock edge after `aresetn` deasserts.
- With a zero-wait slave:
  - A write costs 2 cycles (valids, then B).
  - A read costs 2 cycles (AR, then R).
  - IDLE-to-`vec_valid_o` latency is 3 cycles: IDLE sample, AR, R, with valid registered.
- `vec_valid_o` and `vec_id_o` are stable until the handshake; the consumer may hold `vec_ready_i` high permanently. In that case IAR AW/W are asserted in the cycle after the handshake.
- If AW is accepted before W (or the reverse), the other valid remains asserted until accepted.
- `init_done_o` rises in the cycle after the MER B beat.
- `aresetn` asserted mid-transaction: all outputs return to reset values asynchronously. After release the sequence restarts at INIT_IER, which re-programs the intc (it is reset on the same `aresetn`).

## Structure
- Package `intc_seq_pkg` holds:
  - register offset localparams;
  - the FSM state enum;
  - the `IVR_NONE` = 32'hFFFF_FFFF constant.
- One sub-module, `intc_lite_xfer`: a single-transaction AXI-Lite master engine.
  - Inputs: start, we, addr, wdata.
  - Outputs: done, rdata, resp_err.
  - The top FSM only sequences requests through it.

## Test plan
- Reset release against a zero-wait slave model: writes IER = 0xFF, then MER = 0x3, in order; `init_done_o` = 1 on the cycle after the second B; no further traffic while `irq_i` = 0.
- `irq_i` = 1 with IVR = 5 and `vec_ready_i` held high: `vec_id_o` = 5 with `vec_valid_o` for 1 cycle, then IAR write of 0x20.
- IVR returns 0xFFFF_FFFF 300 times: no `vec_valid_o`; `spurious_cnt_o` saturates at 255.
- Slave delays AW ready by 3 cycles and W ready by 1 cycle: W valid drops first, AW valid holds until accepted, exactly one B consumed.
- Slave returns SLVERR on the IER write: `err_o` = 1 and stays 1; MER is still written and `init_done_o` still rises.
- `aresetn` pulsed low during PRESENT with `vec_id_o` = 3: `vec_valid_o` = 0 immediately; after release, init restarts with an IER write and no IAR write is issued.

Source files
------------

// File: rtl/intc_irq_sequencer_pkg.sv
// Shared constants and types for the interrupt-controller sequencer:
// intc register map, FSM state encoding and the IER masking helper.
package intc_seq_pkg;

    localparam logic [31:0] IER_OFS    = 32'h08;
    localparam logic [31:0] IAR_OFS    = 32'h0C;
    localparam logic [31:0] IVR_OFS    = 32'h18;
    localparam logic [31:0] MER_OFS    = 32'h1C;
    localparam logic [31:0] IVR_NONE   = 32'hFFFF_FFFF;
    localparam logic [31:0] MER_ENABLE = 32'h3;  // ME | HIE
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_INIT_IER = 3'd0,
        ST_INIT_MER = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RD_IVR   = 3'd3,
        ST_PRESENT  = 3'd4,
        ST_WR_IAR   = 3'd5
    } state_e;

    // Clears enable bits for sources the controller does not implement.
    function automatic logic [31:0] ier_mask(input int unsigned n, input logic [31:0] v);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return v & m[31:0];
    endfunction

endpackage

// File: rtl/intc_irq_sequencer_if.sv
// AXI-Lite bus bundle (32-bit address/data) between the sequencer and the intc wrapper.
// Handshake: a beat transfers on a rising clk edge where both VALID and READY are high;
// a master never drops VALID before READY and holds address/data stable meanwhile.
interface axi_lite_if;
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/intc_irq_sequencer_xfer.sv
// Single-outstanding AXI-Lite master engine: one write (AW+W, then B) or one read
// (AR, then R) per start pulse; done/rdata/resp_err are valid in the response beat cycle.
module intc_lite_xfer
    import intc_seq_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    axi_lite_if.master  mst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        resp_err
);

    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        ar_valid_q, ar_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        r_ready_q, r_ready_d;
    logic        busy_q, busy_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        b_beat, r_beat;

    assign b_beat   = mst.b_valid && b_ready_q;
    assign r_beat   = mst.r_valid && r_ready_q;
    assign done     = b_beat || r_beat;
    assign resp_err = (b_beat && (mst.b_resp != RESP_OKAY)) || (r_beat && (mst.r_resp != RESP_OKAY));
    assign rdata    = mst.r_data;
    assign busy     = busy_q;

    always_comb begin
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        busy_d     = busy_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        // AW and W retire independently, so either may be accepted first.
        if (aw_valid_q && mst.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && mst.w_ready)   w_valid_d  = 1'b0;
        if (ar_valid_q && mst.ar_ready) ar_valid_d = 1'b0;
        if (b_beat) b_ready_d = 1'b0;
        if (r_beat) r_ready_d = 1'b0;
        if (done)   busy_d    = 1'b0;
        // A new request may be issued in the same cycle as the previous response beat.
        if (start) begin
            busy_d  = 1'b1;
            addr_d  = addr;
            wdata_d = wdata;
            if (we) begin
                aw_valid_d = 1'b1;
                w_valid_d  = 1'b1;
                b_ready_d  = 1'b1;
            end else begin
                ar_valid_d = 1'b1;
                r_ready_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mst.aw_addr  = addr_q;
    assign mst.aw_valid = aw_valid_q;
    assign mst.w_data   = wdata_q;
    assign mst.w_strb   = 4'hF;
    assign mst.w_valid  = w_valid_q;
    assign mst.b_ready  = b_ready_q;
    assign mst.ar_addr  = addr_q;
    assign mst.ar_valid = ar_valid_q;
    assign mst.r_ready  = r_ready_q;

endmodule

// File: rtl/intc_irq_sequencer.sv
// Programs the axi_intc (IER, then MER) after reset, then services its irq:
// read IVR, present the vector to the consumer, acknowledge through IAR.
module intc_irq_sequencer
    import intc_seq_pkg::*;
#(
    parameter int          C_NUM_INTR_INPUTS = 8,
    parameter logic [31:0] C_BASE_ADDR       = 32'h0,
    parameter logic [31:0] C_IER_INIT        = 32'hFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi_lite_if.master  mst,
    input  logic        irq_i,
    output logic        init_done_o,
    output logic        vec_valid_o,
    output logic [4:0]  vec_id_o,
    input  logic        vec_ready_i,
    output logic        err_o,
    output logic [7:0]  spurious_cnt_o,
    output logic [2:0]  dbg_state_o
);

    localparam logic [31:0] IER_VAL = ier_mask(C_NUM_INTR_INPUTS, C_IER_INIT);

    state_e      state_q, state_d;
    logic        init_done_q, init_done_d;
    logic        vec_valid_q, vec_valid_d;
    logic [4:0]  vec_id_q, vec_id_d;
    logic        err_q, err_d;
    logic [7:0]  spur_q, spur_d;
    logic        x_start, x_we, x_busy, x_done, x_resp_err;
    logic [31:0] x_addr, x_wdata, x_rdata;

    intc_lite_xfer u_xfer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .mst      (mst),
        .start    (x_start),
        .we       (x_we),
        .addr     (x_addr),
        .wdata    (x_wdata),
        .busy     (x_busy),
        .done     (x_done),
        .rdata    (x_rdata),
        .resp_err (x_resp_err)
    );

    // Each request is issued on the transition into the state that waits for it.
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        vec_valid_d = vec_valid_q;
        vec_id_d    = vec_id_q;
        err_d       = err_q | x_resp_err;
        spur_d      = spur_q;
        x_start     = 1'b0;
        x_we        = 1'b0;
        x_addr      = C_BASE_ADDR;
        x_wdata     = '0;
        case (state_q)
            ST_INIT_IER: begin
                if (!x_busy) begin
                    x_start = 1'b1;
                    x_we    = 1'b1;
                    x_addr  = C_BASE_ADDR + IER_OFS;
                    x_wdata = IER_VAL;
                end else if (x_done) begin
                    state_d = ST_INIT_MER;
                    x_start = 1'b1;
                    x_we    = 1'b1;
                    x_addr  = C_BASE_ADDR + MER_OFS;
                    x_wdata = MER_ENABLE;
                end
            end
            ST_INIT_MER: begin
                if (x_done) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (irq_i) begin
                    state_d = ST_RD_IVR;
                    x_start = 1'b1;
                    x_addr  = C_BASE_ADDR + IVR_OFS;
                end
            end
            ST_RD_IVR: begin
                if (x_done) begin
                    if (x_rdata == IVR_NONE) begin
                        if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        vec_id_d    = x_rdata[4:0];
                        vec_valid_d = 1'b1;
                        state_d     = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (vec_ready_i) begin
                    vec_valid_d = 1'b0;
                    state_d     = ST_WR_IAR;
                    x_start     = 1'b1;
                    x_we        = 1'b1;
                    x_addr      = C_BASE_ADDR + IAR_OFS;
                    x_wdata     = 32'h1 << vec_id_q;
                end
            end
            ST_WR_IAR: begin
                if (x_done) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_IER;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_INIT_IER;
            init_done_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            err_q       <= 1'b0;
            spur_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
            err_q       <= err_d;
            spur_q      <= spur_d;
        end
    end

    assign init_done_o    = init_done_q;
    assign vec_valid_o    = vec_valid_q;
    assign vec_id_o       = vec_id_q;
    assign err_o          = err_q;
    assign spurious_cnt_o = spur_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_intc_irq_sequencer.sv
// Directed bench for intc_irq_sequencer against a small AXI-Lite intc slave model
// with programmable ready delays, error injection and IVR value.
module tb_intc_irq_sequencer;

    logic        clk;
    logic        aresetn;
    logic        irq_i;
    logic        init_done_o;
    logic        vec_valid_o;
    logic [4:0]  vec_id_o;
    logic        vec_ready_i;
    logic        err_o;
    logic [7:0]  spurious_cnt_o;
    logic [2:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] wr_q[$];

    int          aw_delay = 0;
    int          w_delay = 0;
    int          err_wr_idx = -1;
    int          wr_idx;
    int          aw_cnt;
    int          w_cnt;
    int          b_cnt = 0;
    int          ar_cnt = 0;
    int          vv_cycles = 0;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_a;
    logic [31:0] w_d;
    logic [31:0] ivr_val = 32'h0;
    logic        aw_hs, w_hs, ar_hs;

    axi_lite_if bus ();

    intc_irq_sequencer dut (
        .aclk           (clk),
        .aresetn        (aresetn),
        .mst            (bus),
        .irq_i          (irq_i),
        .init_done_o    (init_done_o),
        .vec_valid_o    (vec_valid_o),
        .vec_id_o       (vec_id_o),
        .vec_ready_i    (vec_ready_i),
        .err_o          (err_o),
        .spurious_cnt_o (spurious_cnt_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- intc slave model ----------------
    assign bus.aw_ready = !aw_got && !bus.b_valid && (aw_cnt >= aw_delay);
    assign bus.w_ready  = !w_got && !bus.b_valid && (w_cnt >= w_delay);
    assign bus.ar_ready = !bus.r_valid;
    assign aw_hs = bus.aw_valid && bus.aw_ready;
    assign w_hs  = bus.w_valid && bus.w_ready;
    assign ar_hs = bus.ar_valid && bus.ar_ready;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_cnt      <= 0;
            w_cnt       <= 0;
            aw_a        <= '0;
            w_d         <= '0;
            wr_idx      <= 0;
            bus.b_valid <= 1'b0;
            bus.b_resp  <= 2'b00;
            bus.r_valid <= 1'b0;
            bus.r_data  <= '0;
            bus.r_resp  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= bus.aw_addr;
                aw_cnt <= 0;
            end else if (bus.aw_valid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d   <= bus.w_data;
                w_cnt <= 0;
            end else if (bus.w_valid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.b_valid) begin
                bus.b_valid <= 1'b1;
                bus.b_resp  <= (wr_idx == err_wr_idx) ? 2'b10 : 2'b00;
                wr_idx      <= wr_idx + 1;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                wr_q.push_back({(aw_got ? aw_a : bus.aw_addr), (w_got ? w_d : bus.w_data)});
            end
            if (bus.b_valid && bus.b_ready) begin
                bus.b_valid <= 1'b0;
                b_cnt       <= b_cnt + 1;
            end
            if (ar_hs) begin
                bus.r_valid <= 1'b1;
                bus.r_data  <= ivr_val;
                bus.r_resp  <= 2'b00;
                ar_cnt      <= ar_cnt + 1;
            end
            if (bus.r_valid && bus.r_ready) bus.r_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (vec_valid_o === 1'b1) vv_cycles++;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] e;
        logic [63:0] a;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (wr_q.size() != 0) a = wr_q.pop_front();
            else a = 64'hDEAD_DEAD_DEAD_DEAD;
            check(tag, a, e);
        end
        check({tag, "_extra"}, 64'(wr_q.size()), 64'd0);
        wr_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  b0;
        int  ar0;
        bit  mid_seen;

        aresetn     = 1'b0;
        irq_i       = 1'b0;
        vec_ready_i = 1'b0;
        step(3);

        // Reset values
        check("rst_aw_valid", bus.aw_valid, 1'b0);
        check("rst_w_valid", bus.w_valid, 1'b0);
        check("rst_ar_valid", bus.ar_valid, 1'b0);
        check("rst_b_ready", bus.b_ready, 1'b0);
        check("rst_r_ready", bus.r_ready, 1'b0);
        check("rst_init_done", init_done_o, 1'b0);
        check("rst_vec_valid", vec_valid_o, 1'b0);
        check("rst_vec_id", vec_id_o, 5'd0);
        check("rst_err", err_o, 1'b0);
        check("rst_spur", spurious_cnt_o, 8'd0);
        check("rst_state", dbg_state_o, 3'd0);

        // Init sequence: IER then MER
        aresetn = 1'b1;
        step(1);
        check("ier_aw_valid", bus.aw_valid, 1'b1);
        check("ier_w_valid", bus.w_valid, 1'b1);
        check("ier_aw_addr", bus.aw_addr, 32'h08);
        check("ier_w_data", bus.w_data, 32'hFF);
        check("ier_w_strb", bus.w_strb, 4'hF);
        check("ier_b_ready", bus.b_ready, 1'b1);
        step(1);
        check("ier_aw_drop", bus.aw_valid, 1'b0);
        check("ier_w_drop", bus.w_valid, 1'b0);
        step(1);
        check("mer_aw_valid", bus.aw_valid, 1'b1);
        check("mer_aw_addr", bus.aw_addr, 32'h1C);
        check("mer_w_data", bus.w_data, 32'h3);
        check("mer_init_done_lo", init_done_o, 1'b0);
        step(1);
        check("mer_b_init_done_lo", init_done_o, 1'b0);
        step(1);
        check("init_done_rise", init_done_o, 1'b1);
        check("init_state_idle", dbg_state_o, 3'd2);
        step(10);
        exp_q.push_back({32'h08, 32'hFF});
        exp_q.push_back({32'h1C, 32'h3});
        check_writes("init_writes");
        check("init_no_reads", ar_cnt, 0);
        check("init_quiet_aw", bus.aw_valid, 1'b0);

        // Vector 5 with consumer always ready
        ivr_val     = 32'd5;
        vec_ready_i = 1'b1;
        irq_i       = 1'b1;
        step(1);
        irq_i = 1'b0;
        check("v5_ar_valid", bus.ar_valid, 1'b1);
        check("v5_ar_addr", bus.ar_addr, 32'h18);
        check("v5_r_ready", bus.r_ready, 1'b1);
        step(1);
        check("v5_ar_drop", bus.ar_valid, 1'b0);
        check("v5_not_yet_valid", vec_valid_o, 1'b0);
        step(1);
        check("v5_vec_valid", vec_valid_o, 1'b1);
        check("v5_vec_id", vec_id_o, 5'd5);
        step(1);
        check("v5_vec_valid_drop", vec_valid_o, 1'b0);
        check("v5_iar_aw_valid", bus.aw_valid, 1'b1);
        check("v5_iar_addr", bus.aw_addr, 32'h0C);
        check("v5_iar_data", bus.w_data, 32'h20);
        step(5);
        exp_q.push_back({32'h0C, 32'h20});
        check_writes("v5_writes");
        check("v5_valid_cycles", vv_cycles, 1);
        check("v5_state_idle", dbg_state_o, 3'd2);

        // 300 spurious IVR reads
        ivr_val     = 32'hFFFF_FFFF;
        vec_ready_i = 1'b0;
        irq_i       = 1'b1;
        mid_seen    = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step(1);
            if (ar_cnt == 101 && !mid_seen) begin
                mid_seen = 1'b1;
                check("spur_mid_count", spurious_cnt_o, 8'd99);
            end
            if (ar_cnt >= 301) break;
        end
        irq_i = 1'b0;
        check("spur_read_budget", ar_cnt, 301);
        step(4);
        check("spur_saturated", spurious_cnt_o, 8'd255);
        check("spur_no_vec", vv_cycles, 1);
        check("spur_reads_stop", ar_cnt, 301);
        check("spur_state_idle", dbg_state_o, 3'd2);
        check_writes("spur_no_writes");

        // IAR write with AW delayed 3 cycles, W delayed 1 cycle
        ivr_val     = 32'd2;
        vec_ready_i = 1'b1;
        aw_delay    = 3;
        w_delay     = 1;
        b0          = b_cnt;
        irq_i       = 1'b1;
        step(1);
        irq_i = 1'b0;
        step(3);
        check("dly_h0_aw", bus.aw_valid, 1'b1);
        check("dly_h0_w", bus.w_valid, 1'b1);
        step(1);
        check("dly_h1_aw", bus.aw_valid, 1'b1);
        check("dly_h1_w", bus.w_valid, 1'b1);
        step(1);
        check("dly_h2_aw_hold", bus.aw_valid, 1'b1);
        check("dly_h2_w_drop", bus.w_valid, 1'b0);
        step(1);
        check("dly_h3_aw_hold", bus.aw_valid, 1'b1);
        step(1);
        check("dly_h4_aw_drop", bus.aw_valid, 1'b0);
        check("dly_h4_b_ready", bus.b_ready, 1'b1);
        step(1);
        check("dly_h5_b_ready_drop", bus.b_ready, 1'b0);
        check("dly_h5_idle", dbg_state_o, 3'd2);
        step(3);
        check("dly_one_b", b_cnt, b0 + 1);
        exp_q.push_back({32'h0C, 32'h4});
        check_writes("dly_writes");
        aw_delay = 0;
        w_delay  = 0;

        // SLVERR on the IER write
        err_wr_idx  = 0;
        vec_ready_i = 1'b0;
        aresetn     = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(1);
        check("slverr_ier_start", bus.aw_addr, 32'h08);
        step(1);
        check("slverr_err_before_b", err_o, 1'b0);
        step(1);
        check("slverr_err_set", err_o, 1'b1);
        check("slverr_mer_issued", bus.aw_addr, 32'h1C);
        step(2);
        check("slverr_init_done", init_done_o, 1'b1);
        err_wr_idx = -1;
        step(10);
        check("slverr_err_sticky", err_o, 1'b1);
        exp_q.push_back({32'h08, 32'hFF});
        exp_q.push_back({32'h1C, 32'h3});
        check_writes("slverr_writes");

        // Reset while presenting vector 3
        ar0     = ar_cnt;
        ivr_val = 32'd3;
        irq_i   = 1'b1;
        step(1);
        irq_i = 1'b0;
        step(2);
        check("rp_vec_valid", vec_valid_o, 1'b1);
        check("rp_vec_id", vec_id_o, 5'd3);
        check("rp_state_present", dbg_state_o, 3'd4);
        step(3);
        check("rp_vec_valid_hold", vec_valid_o, 1'b1);
        check("rp_vec_id_hold", vec_id_o, 5'd3);
        #2 aresetn = 1'b0;
        #1;
        check("rp_async_vec_valid", vec_valid_o, 1'b0);
        check("rp_async_vec_id", vec_id_o, 5'd0);
        check("rp_async_err", err_o, 1'b0);
        check("rp_async_init_done", init_done_o, 1'b0);
        check("rp_async_spur", spurious_cnt_o, 8'd0);
        check("rp_async_state", dbg_state_o, 3'd0);
        vec_ready_i = 1'b1;
        step(1);
        aresetn = 1'b1;
        step(1);
        check("rp_restart_aw_valid", bus.aw_valid, 1'b1);
        check("rp_restart_ier_addr", bus.aw_addr, 32'h08);
        step(10);
        check("rp_init_done", init_done_o, 1'b1);
        check("rp_no_vec", vec_valid_o, 1'b0);
        check("rp_no_reads", ar_cnt, ar0 + 1);
        exp_q.push_back({32'h08, 32'hFF});
        exp_q.push_back({32'h1C, 32'h3});
        check_writes("rp_writes_no_iar");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
